// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR sequencer slice.
//   fir_state_t  - sequencer state encoding (also reported on state_o)
//   TAP_NUM      - default number of taps
//   WORD_STRIDE  - byte stride between 32-bit BRAM words
//   OUT_COUNT    - progress-counter value shown while an output is pending
//   ring_index() - circular data RAM index (wp - i) mod n
package fir_pkg;

  // Encoding 3'd2 is reserved; the sequencer recovers from it to S_IDLE.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WAIT_X = 3'd3,
    S_MAC    = 3'd4,
    S_OUT    = 3'd5,
    S_DONE   = 3'd6
  } fir_state_t;

  localparam int         TAP_NUM     = 11;
  localparam int         WORD_STRIDE = 4;
  localparam logic [3:0] OUT_COUNT   = 4'd14;

  // Valid for wp < n and i <= n; never produces a negative index.
  function automatic logic [3:0] ring_index(input logic [3:0] wp,
                                            input logic [3:0] i,
                                            input int         n);
    if (wp >= i) return wp - i;
    return 4'(int'(wp) + n - int'(i));
  endfunction

endpackage

// File: rtl/fir_sequencer_if.sv
// fir_sequencer_if: one AXI-Stream channel (tvalid/tready/tdata/tlast).
//   master - drives tvalid, tdata, tlast; receives tready
//   slave  - receives tvalid, tdata, tlast; drives tready
interface fir_sequencer_if #(
  parameter int DW = 32
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/fir_sequencer_mac.sv
// fir_mac: registered multiply-accumulate.
//   axis_clk, axis_rst_n - clock, asynchronous active-low reset
//   clr                  - zero the accumulator (wins over en)
//   en                   - acc <= acc + a*b (signed, low word kept)
//   a, b                 - operands
//   acc                  - accumulator register
module fir_mac #(
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic [pDATA_WIDTH-1:0] a,
  input  logic [pDATA_WIDTH-1:0] b,
  output logic [pDATA_WIDTH-1:0] acc
);

  logic [pDATA_WIDTH-1:0] prod;

  // Only the low word of the signed product is kept; sum wraps modulo 2^W.
  assign prod = pDATA_WIDTH'($signed(a) * $signed(b));

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n)  acc <= '0;
    else if (clr)     acc <= '0;
    else if (en)      acc <= acc + prod;
  end

endmodule

// File: rtl/fir_sequencer.sv
// fir_sequencer: sequences one FIR run.
//   axis_clk, axis_rst_n     - clock, asynchronous active-low reset
//   ap_start, data_length    - run request and sample count (config block)
//   ap_done, ap_idle         - run status (config block)
//   ss                       - AXI-Stream slave, input samples
//   sm                       - AXI-Stream master, filter outputs
//   fir_raddr, tap_Do        - tap index out, tap RAM read data in
//   data_EN/WE/A/Di, data_Do - data RAM port (circular sample history)
//   state_o, counter         - state encoding and progress counter
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = TAP_NUM
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_start,
  input  logic [31:0]            data_length,
  output logic                   ap_done,
  output logic                   ap_idle,
  fir_sequencer_if.slave         ss,
  fir_sequencer_if.master        sm,
  output logic [3:0]             fir_raddr,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  input  logic [pDATA_WIDTH-1:0] data_Do,
  output logic [2:0]             state_o,
  output logic [3:0]             counter
);

  fir_state_t             state;
  logic [3:0]             wp;
  logic [31:0]            oc;
  logic [3:0]             addr_idx;
  logic                   acc_clr;
  logic                   acc_en;
  logic [pDATA_WIDTH-1:0] acc;
  logic                   unused_tlast;

  // The run length alone terminates the run.
  assign unused_tlast = ss.tlast;

  assign state_o = state;
  assign data_EN = (state != S_IDLE);
  assign sm.tdata = acc;

  // Operands addressed at step i-1 are accumulated at step i.
  assign acc_en  = (state == S_MAC) && (counter != 4'd0);
  assign acc_clr = ((state == S_IDLE) && ap_start) ||
                   ((state == S_OUT) && sm.tready);

  fir_mac #(
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_mac (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .clr        (acc_clr),
    .en         (acc_en),
    .a          (tap_Do),
    .b          (data_Do),
    .acc        (acc)
  );

  always_comb begin
    fir_raddr = '0;
    data_WE   = '0;
    data_Di   = '0;
    addr_idx  = '0;
    unique case (state)
      S_CLEAR: begin
        addr_idx = counter;
        data_WE  = '1;
      end
      S_WAIT_X: begin
        addr_idx = wp;
        if (ss.tvalid) begin
          data_WE = '1;
          data_Di = ss.tdata;
        end
      end
      S_MAC: begin
        if (counter < 4'(Tape_Num)) begin
          fir_raddr = counter;
          addr_idx  = ring_index(wp, counter, Tape_Num);
        end
      end
      default: ;
    endcase
    data_A = pADDR_WIDTH'(int'(addr_idx) * WORD_STRIDE);
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state     <= S_IDLE;
      counter   <= '0;
      wp        <= '0;
      oc        <= '0;
      ap_done   <= 1'b0;
      ap_idle   <= 1'b1;
      ss.tready <= 1'b0;
      sm.tvalid <= 1'b0;
      sm.tlast  <= 1'b0;
    end else begin
      ap_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ap_start) begin
            state   <= S_CLEAR;
            counter <= '0;
            wp      <= '0;
            oc      <= '0;
            ap_idle <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (counter == 4'(Tape_Num - 1)) begin
            counter <= '0;
            if (data_length == 32'd0) begin
              state   <= S_DONE;
              ap_done <= 1'b1;
              ap_idle <= 1'b1;
            end else begin
              state     <= S_WAIT_X;
              ss.tready <= 1'b1;
            end
          end else begin
            counter <= counter + 4'd1;
          end
        end
        S_WAIT_X: begin
          if (ss.tvalid) begin
            state     <= S_MAC;
            ss.tready <= 1'b0;
            counter   <= '0;
          end
        end
        S_MAC: begin
          if (counter == 4'(Tape_Num)) begin
            state     <= S_OUT;
            counter   <= OUT_COUNT;
            sm.tvalid <= 1'b1;
            sm.tlast  <= (oc == data_length - 32'd1);
          end else begin
            counter <= counter + 4'd1;
          end
        end
        S_OUT: begin
          if (sm.tready) begin
            sm.tvalid <= 1'b0;
            sm.tlast  <= 1'b0;
            oc        <= oc + 32'd1;
            wp        <= (wp == 4'(Tape_Num - 1)) ? '0 : wp + 4'd1;
            counter   <= '0;
            if (sm.tlast) begin
              state   <= S_DONE;
              ap_done <= 1'b1;
              ap_idle <= 1'b1;
            end else begin
              state     <= S_WAIT_X;
              ss.tready <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          counter <= '0;
        end
        default: begin
          state     <= S_IDLE;
          counter   <= '0;
          ap_idle   <= 1'b1;
          ss.tready <= 1'b0;
          sm.tvalid <= 1'b0;
          sm.tlast  <= 1'b0;
        end
      endcase
    end
  end

endmodule
